// File: rtl/xor_diff_pipe_if.sv
// Valid/ready bundle for xor_diff_pipe: operand beats in, result beats out.
// The pipe takes the slave view, its source/consumer side takes master.
interface xor_diff_pipe_if #(
    parameter int WIDTH = 3,
    parameter int ACC_W = 16
);
    localparam int ONES_W = $clog2(WIDTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [1:0]        mode;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  y;
    logic [ONES_W-1:0] ones;
    logic [ACC_W-1:0]  acc;
    logic              acc_sat;
    logic              out_last;

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  mode,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y,
        output ones,
        output acc,
        output acc_sat,
        output out_last
    );

    modport master (
        output in_valid,
        output a,
        output b,
        output mode,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y,
        input  ones,
        input  acc,
        input  acc_sat,
        input  out_last
    );
endinterface

// File: rtl/xor_diff_pipe.sv
// Two-stage bitwise combine + popcount pipe with a saturating per-frame
// accumulator; skid-free valid/ready with exactly two beats of buffering.
module xor_diff_pipe #(
    parameter int WIDTH = 3,
    parameter int ACC_W = 16
) (
    input logic            clk,
    input logic            rst_n,
    xor_diff_pipe_if.slave pipe_if
);
    localparam int ONES_W = $clog2(WIDTH + 1);
    localparam int PAD_W  = ACC_W + 1 - ONES_W;

    typedef enum logic [1:0] {
        MODE_XOR  = 2'b00,
        MODE_XNOR = 2'b01,
        MODE_AND  = 2'b10,
        MODE_OR   = 2'b11
    } mode_e;

    logic              s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]  s1_y_q, s1_y_d;
    logic              s1_last_q, s1_last_d;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              sat_q, sat_d;
    logic              last_q, last_d;

    logic [ACC_W-1:0]  run_q, run_d;
    logic              run_sat_q, run_sat_d;

    logic              s2_load;
    logic              s1_adv;
    logic              in_rdy;
    logic              accept;
    logic [WIDTH-1:0]  f_y;
    logic [ONES_W-1:0] pop;
    logic [ACC_W:0]    sum;
    logic              ovf;
    logic [ACC_W-1:0]  acc_nx;
    logic              sat_nx;

    assign s2_load = !out_valid_q || pipe_if.out_ready;
    assign s1_adv  = s1_valid_q && s2_load;
    assign in_rdy  = !s1_valid_q || s2_load;
    assign accept  = pipe_if.in_valid && in_rdy;

    always_comb begin
        f_y = '0;
        unique case (mode_e'(pipe_if.mode))
            MODE_XOR:  f_y = pipe_if.a ^ pipe_if.b;
            MODE_XNOR: f_y = ~(pipe_if.a ^ pipe_if.b);
            MODE_AND:  f_y = pipe_if.a & pipe_if.b;
            MODE_OR:   f_y = pipe_if.a | pipe_if.b;
        endcase
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + ONES_W'(s1_y_q[i]);
        end
    end

    // One spare bit catches the carry out, then clamp to all-ones.
    assign sum    = {1'b0, run_q} + {{PAD_W{1'b0}}, pop};
    assign ovf    = sum[ACC_W];
    assign acc_nx = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    assign sat_nx = run_sat_q || ovf;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_y_d     = s1_y_q;
        s1_last_d  = s1_last_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_y_d     = f_y;
            s1_last_d  = pipe_if.in_last;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = s2_load ? s1_valid_q : out_valid_q;
        y_d         = y_q;
        ones_d      = ones_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        last_d      = last_q;
        run_d       = run_q;
        run_sat_d   = run_sat_q;
        if (s1_adv) begin
            y_d       = s1_y_q;
            ones_d    = pop;
            acc_d     = acc_nx;
            sat_d     = sat_nx;
            last_d    = s1_last_q;
            run_d     = s1_last_q ? '0 : acc_nx;
            run_sat_d = s1_last_q ? 1'b0 : sat_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_y_q      <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            ones_q      <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            last_q      <= 1'b0;
            run_q       <= '0;
            run_sat_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_y_q      <= s1_y_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            ones_q      <= ones_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            last_q      <= last_d;
            run_q       <= run_d;
            run_sat_q   <= run_sat_d;
        end
    end

    assign pipe_if.in_ready  = in_rdy;
    assign pipe_if.out_valid = out_valid_q;
    assign pipe_if.y         = y_q;
    assign pipe_if.ones      = ones_q;
    assign pipe_if.acc       = acc_q;
    assign pipe_if.acc_sat   = sat_q;
    assign pipe_if.out_last  = last_q;
endmodule

// File: tb/tb_xor_diff_pipe.sv
// Scoreboard bench for xor_diff_pipe: a 4-bit/16-bit instance for the main
// datapath and handshake, a 3-bit/3-bit instance for saturation.
module tb_xor_diff_pipe;
    localparam int W0 = 4;
    localparam int A0 = 16;
    localparam int W1 = 3;
    localparam int A1 = 3;

    typedef struct packed {
        logic [7:0]  y;
        logic [7:0]  ones;
        logic [15:0] acc;
        logic        sat;
        logic        last;
    } res_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errs = 0;
    res_t q0[$];
    res_t q1[$];
    int   m_run[2];
    bit   m_sat[2];

    xor_diff_pipe_if #(.WIDTH(W0), .ACC_W(A0)) o0 ();
    xor_diff_pipe_if #(.WIDTH(W1), .ACC_W(A1)) o1 ();

    xor_diff_pipe #(.WIDTH(W0), .ACC_W(A0)) u0 (
        .clk(clk), .rst_n(rst_n), .pipe_if(o0)
    );
    xor_diff_pipe #(.WIDTH(W1), .ACC_W(A1)) u1 (
        .clk(clk), .rst_n(rst_n), .pipe_if(o1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input int u, input logic [7:0] a,
                                   input logic [7:0] b, input logic [1:0] md,
                                   input logic last);
        res_t r;
        int w, mx, tot;
        logic [7:0] v;
        w  = (u == 0) ? W0 : W1;
        mx = (u == 0) ? (1 << A0) - 1 : (1 << A1) - 1;
        case (md)
            2'b00:   v = a ^ b;
            2'b01:   v = ~(a ^ b);
            2'b10:   v = a & b;
            default: v = a | b;
        endcase
        v = v & 8'((1 << w) - 1);
        tot = m_run[u] + $countones(v);
        r.y    = v;
        r.ones = 8'($countones(v));
        r.acc  = 16'((tot > mx) ? mx : tot);
        r.sat  = m_sat[u] || (tot > mx);
        r.last = last;
        m_run[u] = last ? 0 : int'(r.acc);
        m_sat[u] = last ? 1'b0 : r.sat;
        return r;
    endfunction

    function automatic res_t obs(input int u);
        res_t r;
        if (u == 0)
            r = '{y: 8'(o0.y), ones: 8'(o0.ones), acc: 16'(o0.acc),
                  sat: o0.acc_sat, last: o0.out_last};
        else
            r = '{y: 8'(o1.y), ones: 8'(o1.ones), acc: 16'(o1.acc),
                  sat: o1.acc_sat, last: o1.out_last};
        return r;
    endfunction

    function automatic res_t pop(input int u);
        res_t r = '1;
        if (u == 0) begin
            if (q0.size() > 0) r = q0.pop_front();
        end else if (q1.size() > 0) begin
            r = q1.pop_front();
        end
        return r;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("y=%h ones=%0d acc=%0d sat=%b last=%b",
                         r.y, r.ones, r.acc, r.sat, r.last);
    endfunction

    // Drive one beat and hold it until accepted; leaves in_valid high.
    task automatic put(input int u, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] md, input logic last);
        int n = 0;
        bit rdy;
        if (u == 0) begin
            o0.in_valid = 1'b1; o0.a = a[3:0]; o0.b = b[3:0];
            o0.mode = md; o0.in_last = last;
        end else begin
            o1.in_valid = 1'b1; o1.a = a[2:0]; o1.b = b[2:0];
            o1.mode = md; o1.in_last = last;
        end
        do begin
            @(negedge clk);
            rdy = (u == 0) ? o0.in_ready : o1.in_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            checks++; errs++;
            $display("FAIL put_timeout u%0d: in_ready=0 for %0d cycles, required 1", u, n);
            if (u == 0) o0.in_valid = 1'b0; else o1.in_valid = 1'b0;
        end else if (u == 0) begin
            q0.push_back(model(0, a, b, md, last));
        end else begin
            q1.push_back(model(1, a, b, md, last));
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        o0.in_valid = 0; o0.a = 0; o0.b = 0; o0.mode = 0; o0.in_last = 0;
        o0.out_ready = 1;
        o1.in_valid = 0; o1.a = 0; o1.b = 0; o1.mode = 0; o1.in_last = 0;
        o1.out_ready = 1;
        m_run[0] = 0; m_run[1] = 0; m_sat[0] = 0; m_sat[1] = 0;
        #1;
        checks++;
        if (o0.out_valid !== 1'b0 || o1.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_out_valid: got %b/%b, required 0/0", o0.out_valid, o1.out_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o0.in_ready !== 1'b1 || o1.in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_in_ready: got %b/%b, required 1/1", o0.in_ready, o1.in_ready);
        end
        checks++;
        if (obs(0) !== '0 || o0.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_outs_u0: got %s valid=%b, required all 0", fmt(obs(0)), o0.out_valid);
        end
        checks++;
        if (obs(1) !== '0 || o1.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_outs_u1: got %s valid=%b, required all 0", fmt(obs(1)), o1.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        res_t e;
        o1.out_ready = 1'b1;
        put(1, 8'b110, 8'b011, 2'b00, 1'b1);
        o1.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o1.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL basic_latency_early: out_valid=%b, required 0", o1.out_valid);
        end
        @(negedge clk);
        e = pop(1);
        checks++;
        if (o1.out_valid !== 1'b1 || obs(1) !== e) begin
            errs++;
            $display("FAIL basic_beat: got valid=%b %s, required valid=1 %s", o1.out_valid, fmt(obs(1)), fmt(e));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        res_t got, e;
        int k = 0, cyc = 0;
        o1.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    put(1, 8'b111, 8'b000, 2'b00, i == 3);
                o1.in_valid = 1'b0;
            end
            begin
                while (k < 5 && cyc < 200) begin
                    @(negedge clk); cyc++;
                    if (o1.out_valid && o1.out_ready) begin
                        got = obs(1); e = pop(1); checks++; k++;
                        if (got !== e) begin
                            errs++;
                            $display("FAIL sat[%0d]: got %s, required %s", k, fmt(got), fmt(e));
                        end
                    end
                end
                if (k < 5) begin
                    checks++; errs++;
                    $display("FAIL sat_timeout: got %0d beats, required 5", k);
                end
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic test_modes();
        res_t got, e;
        int k = 0, cyc = 0;
        o0.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    put(0, 8'b1100, 8'b1010, 2'(i), i == 3);
                o0.in_valid = 1'b0;
            end
            begin
                while (k < 4 && cyc < 200) begin
                    @(negedge clk); cyc++;
                    if (o0.out_valid && o0.out_ready) begin
                        got = obs(0); e = pop(0); checks++; k++;
                        if (got !== e) begin
                            errs++;
                            $display("FAIL modes[%0d]: got %s, required %s", k, fmt(got), fmt(e));
                        end
                    end
                end
                if (k < 4) begin
                    checks++; errs++;
                    $display("FAIL modes_timeout: got %0d beats, required 4", k);
                end
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        res_t got, e;
        int k = 0, cyc = 0;
        o0.out_ready = 1'b0;
        put(0, 8'h1, 8'h0, 2'b00, 1'b0);
        put(0, 8'h3, 8'h0, 2'b00, 1'b0);
        o0.a = 4'h7; o0.in_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o0.in_ready !== 1'b0) begin
                errs++;
                $display("FAIL bp_in_ready: got %b, required 0", o0.in_ready);
            end
            checks++;
            if (o0.out_valid !== 1'b1 || obs(0) !== q0[0]) begin
                errs++;
                $display("FAIL bp_frozen: got valid=%b %s, required valid=1 %s", o0.out_valid, fmt(obs(0)), fmt(q0[0]));
            end
        end
        @(posedge clk); #1;
        o0.out_ready = 1'b1;
        #1;
        checks++;
        if (o0.in_ready !== 1'b1) begin
            errs++;
            $display("FAIL bp_release: in_ready=%b, required 1", o0.in_ready);
        end
        fork
            begin
                put(0, 8'h7, 8'h0, 2'b00, 1'b1);
                o0.in_valid = 1'b0;
            end
            begin
                while (k < 3 && cyc < 200) begin
                    @(negedge clk); cyc++;
                    if (o0.out_valid && o0.out_ready) begin
                        got = obs(0); e = pop(0); checks++; k++;
                        if (got !== e) begin
                            errs++;
                            $display("FAIL bp_drain[%0d]: got %s, required %s", k, fmt(got), fmt(e));
                        end
                    end
                end
                if (k < 3) begin
                    checks++; errs++;
                    $display("FAIL bp_timeout: got %0d beats, required 3", k);
                end
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic test_frame_restart();
        res_t got, e;
        int k = 0, cyc = 0;
        o0.out_ready = 1'b1;
        fork
            begin
                put(0, 8'h1, 8'h0, 2'b00, 1'b0);
                put(0, 8'h3, 8'h0, 2'b00, 1'b1);
                put(0, 8'h7, 8'h0, 2'b00, 1'b0);
                o0.in_valid = 1'b0;
            end
            begin
                while (k < 3 && cyc < 200) begin
                    @(negedge clk); cyc++;
                    if (o0.out_valid && o0.out_ready) begin
                        got = obs(0); e = pop(0); checks++; k++;
                        if (got !== e) begin
                            errs++;
                            $display("FAIL restart[%0d]: got %s, required %s", k, fmt(got), fmt(e));
                        end
                    end
                end
                if (k < 3) begin
                    checks++; errs++;
                    $display("FAIL restart_timeout: got %0d beats, required 3", k);
                end
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        res_t e;
        o0.out_ready = 1'b1;
        put(0, 8'h3, 8'h0, 2'b00, 1'b0);
        o0.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        e = pop(0);
        checks++;
        if (o0.out_valid !== 1'b1 || obs(0) !== e) begin
            errs++;
            $display("FAIL ar_pre: got valid=%b %s, required valid=1 %s", o0.out_valid, fmt(obs(0)), fmt(e));
        end
        @(posedge clk); #1;
        o0.out_ready = 1'b0;
        put(0, 8'h1, 8'h0, 2'b00, 1'b0);
        put(0, 8'h1, 8'h0, 2'b00, 1'b0);
        o0.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o0.out_valid !== 1'b1 || o0.in_ready !== 1'b0) begin
            errs++;
            $display("FAIL ar_full: valid=%b in_ready=%b, required 1/0", o0.out_valid, o0.in_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (o0.out_valid !== 1'b0 || obs(0) !== '0) begin
            errs++;
            $display("FAIL ar_async_clear: got valid=%b %s, required all 0", o0.out_valid, fmt(obs(0)));
        end
        q0.delete(); q1.delete();
        m_run[0] = 0; m_run[1] = 0; m_sat[0] = 0; m_sat[1] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        o0.out_ready = 1'b1;
        put(0, 8'h1, 8'h0, 2'b00, 1'b1);
        o0.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o0.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL ar_ghost: out_valid=%b before new beat, required 0", o0.out_valid);
        end
        @(negedge clk);
        e = pop(0);
        checks++;
        if (o0.out_valid !== 1'b1 || obs(0) !== e) begin
            errs++;
            $display("FAIL ar_post: got valid=%b %s, required valid=1 %s", o0.out_valid, fmt(obs(0)), fmt(e));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        res_t got, e;
        int k = 0, cyc = 0, first = -1, lastc = -1;
        o0.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    put(0, 8'(i * 5), 8'(i * 3), 2'(i), i == 7);
                o0.in_valid = 1'b0;
            end
            begin
                while (k < 8 && cyc < 200) begin
                    @(negedge clk); cyc++;
                    if (o0.out_valid && o0.out_ready) begin
                        got = obs(0); e = pop(0); checks++; k++;
                        if (first < 0) first = cyc;
                        lastc = cyc;
                        if (got !== e) begin
                            errs++;
                            $display("FAIL b2b[%0d]: got %s, required %s", k, fmt(got), fmt(e));
                        end
                    end
                end
            end
        join
        checks++;
        if (k != 8 || lastc - first != 7) begin
            errs++;
            $display("FAIL b2b_throughput: %0d beats over %0d cycles, required 8 over 8", k, lastc - first + 1);
        end
        @(posedge clk); #1;
        k = 0; cyc = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        o0.in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    put(0, 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
                        $urandom_range(0, 3) == 0);
                end
                o0.in_valid = 1'b0;
            end
            begin
                while (k < 40 && cyc < 3000) begin
                    @(negedge clk); cyc++;
                    if (o0.out_valid && o0.out_ready) begin
                        got = obs(0); e = pop(0); checks++; k++;
                        if (got !== e) begin
                            errs++;
                            $display("FAIL rand[%0d]: got %s, required %s", k, fmt(got), fmt(e));
                        end
                    end
                    if (k < 40) begin
                        @(posedge clk); #1;
                        o0.out_ready = ($urandom_range(0, 3) != 0);
                    end
                end
                if (k < 40) begin
                    checks++; errs++;
                    $display("FAIL rand_timeout: got %0d beats, required 40", k);
                end
            end
        join
        @(posedge clk); #1;
        o0.out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_modes();
        test_backpressure();
        test_frame_restart();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
